// File: rtl/issue_queue.sv
// Out-of-order issue queue: circular buffer of decoded instructions that wait
// for their source operands, get woken by writeback broadcasts, and issue
// oldest-ready-first. Issued entries are reclaimed in order from the head.
//
// Per-entry state table:
//   state   | meaning
//   --------+----------------------------------------------------------
//   FREE    | slot empty
//   WAITING | holds an instruction with at least one source outstanding
//   READY   | both sources available, candidate for select
//   ISSUED  | sent to execute, waits at or behind head for reclaim
module issue_queue #(
    parameter int DEPTH     = 8,
    parameter int TAG_W     = 6,
    parameter int PAYLOAD_W = 64,
    parameter int WB_PORTS  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      enq_valid,
    output logic                      enq_ready,
    input  logic [PAYLOAD_W-1:0]      enq_payload,
    input  logic [TAG_W-1:0]          enq_src1_tag,
    input  logic [TAG_W-1:0]          enq_src2_tag,
    input  logic                      enq_src1_rdy,
    input  logic                      enq_src2_rdy,
    input  logic [WB_PORTS-1:0]       wb_valid,
    input  logic [WB_PORTS*TAG_W-1:0] wb_tag,
    output logic                      iss_valid,
    input  logic                      iss_ready,
    output logic [PAYLOAD_W-1:0]      iss_payload,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        WAITING = 2'd1,
        READY   = 2'd2,
        ISSUED  = 2'd3
    } ent_state_t;

    ent_state_t           state_q [DEPTH];
    ent_state_t           state_d [DEPTH];
    logic                 ok1_q   [DEPTH];
    logic                 ok1_d   [DEPTH];
    logic                 ok2_q   [DEPTH];
    logic                 ok2_d   [DEPTH];
    logic [PAYLOAD_W-1:0] payload_q [DEPTH];
    logic [TAG_W-1:0]     tag1_q  [DEPTH];
    logic [TAG_W-1:0]     tag2_q  [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [PW-1:0] sel_idx;
    logic [PW-1:0] scan_idx;
    logic          sel_found;
    logic          enq_fire;
    logic          iss_fire;
    logic          reclaim;
    logic          enq_ok1;
    logic          enq_ok2;

    // True when any valid writeback port broadcasts this tag.
    function automatic logic tag_hit(input logic [TAG_W-1:0]          tag,
                                     input logic [WB_PORTS-1:0]       v,
                                     input logic [WB_PORTS*TAG_W-1:0] tags);
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < WB_PORTS; p++) begin
            if (v[p] && (tags[p*TAG_W +: TAG_W] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    // Select: oldest READY entry, scanning forward from head with wrap.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PW'(i);
            if (!sel_found && (state_q[scan_idx] == READY)) begin
                sel_found = 1'b1;
                sel_idx   = scan_idx;
            end
        end
    end

    // Outputs depend only on registered state so enqueue never bypasses to issue.
    always_comb begin
        enq_ready   = (count_q < CW'(DEPTH));
        iss_valid   = sel_found;
        iss_payload = sel_found ? payload_q[sel_idx] : '0;
        count       = count_q;
        enq_fire    = enq_valid && enq_ready && !flush;
        iss_fire    = sel_found && iss_ready && !flush;
        reclaim     = (state_q[head_q] == ISSUED) && !flush;
        enq_ok1     = enq_src1_rdy || (enq_src1_tag == '0) ||
                      tag_hit(enq_src1_tag, wb_valid, wb_tag);
        enq_ok2     = enq_src2_rdy || (enq_src2_tag == '0) ||
                      tag_hit(enq_src2_tag, wb_valid, wb_tag);
    end

    // Next-state: flush wins; otherwise wakeup, issue, reclaim and enqueue
    // touch disjoint slots (tail is FREE whenever enqueue is allowed).
    always_comb begin
        state_d = state_q;
        ok1_d   = ok1_q;
        ok2_d   = ok2_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_d[i] = FREE;
                ok1_d[i]   = 1'b0;
                ok2_d[i]   = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (state_q[i] == WAITING) begin
                    ok1_d[i] = ok1_q[i] || tag_hit(tag1_q[i], wb_valid, wb_tag);
                    ok2_d[i] = ok2_q[i] || tag_hit(tag2_q[i], wb_valid, wb_tag);
                    if (ok1_d[i] && ok2_d[i]) state_d[i] = READY;
                end
            end
            if (iss_fire) state_d[sel_idx] = ISSUED;
            if (reclaim) begin
                state_d[head_q] = FREE;
                head_d          = head_q + PW'(1);
            end
            if (enq_fire) begin
                state_d[tail_q] = (enq_ok1 && enq_ok2) ? READY : WAITING;
                ok1_d[tail_q]   = enq_ok1;
                ok2_d[tail_q]   = enq_ok2;
                tail_d          = tail_q + PW'(1);
            end
            count_d = count_q + CW'(enq_fire) - CW'(reclaim);
        end
    end

    // Control state register; reset clears every slot immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= FREE;
                ok1_q[i]   <= 1'b0;
                ok2_q[i]   <= 1'b0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ok1_q   <= ok1_d;
            ok2_q   <= ok2_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry data storage; contents are don't-care while the slot is FREE.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            payload_q[tail_q] <= enq_payload;
            tag1_q[tail_q]    <= enq_src1_tag;
            tag2_q[tail_q]    <= enq_src2_tag;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: directed scenarios plus random traffic, all checked
// against an age-ordered queue model of the instruction window.
module tb_issue_queue;

    localparam int DEPTH = 8;
    localparam int TAG_W = 6;
    localparam int PW    = 64;
    localparam int WBP   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              enq_valid;
    logic              enq_ready;
    logic [PW-1:0]     enq_payload;
    logic [TAG_W-1:0]  enq_src1_tag, enq_src2_tag;
    logic              enq_src1_rdy, enq_src2_rdy;
    logic [WBP-1:0]    wb_valid;
    logic [WBP*TAG_W-1:0] wb_tag;
    logic              iss_valid;
    logic              iss_ready;
    logic [PW-1:0]     iss_payload;
    logic [3:0]        count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PAYLOAD_W(PW), .WB_PORTS(WBP)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_payload(enq_payload),
        .enq_src1_tag(enq_src1_tag), .enq_src2_tag(enq_src2_tag),
        .enq_src1_rdy(enq_src1_rdy), .enq_src2_rdy(enq_src2_rdy),
        .wb_valid(wb_valid), .wb_tag(wb_tag),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_payload(iss_payload),
        .count(count)
    );

    // Reference window: element 0 is the oldest instruction. st: 0 waiting, 1 ready, 2 issued.
    typedef struct {
        logic [PW-1:0]    pl;
        logic [TAG_W-1:0] t1;
        logic [TAG_W-1:0] t2;
        logic             ok1;
        logic             ok2;
        int               st;
    } ent_t;
    ent_t mq[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic wb_hit(input logic [TAG_W-1:0] t);
        for (int p = 0; p < WBP; p++)
            if (wb_valid[p] && wb_tag[p*TAG_W +: TAG_W] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_outputs();
        logic          exp_v = 1'b0;
        logic [PW-1:0] exp_p = '0;
        for (int i = 0; i < mq.size(); i++)
            if (!exp_v && mq[i].st == 1) begin
                exp_v = 1'b1;
                exp_p = mq[i].pl;
            end
        check("iss_valid", 64'(iss_valid), 64'(exp_v));
        check("iss_payload", iss_payload, exp_p);
        check("count", 64'(count), 64'(mq.size()));
        check("enq_ready", 64'(enq_ready), 64'(mq.size() < DEPTH));
    endtask

    task automatic model_update();
        int   sel = -1;
        bit   rec;
        bit   enq;
        ent_t e;
        if (flush) begin
            mq.delete();
            return;
        end
        for (int i = 0; i < mq.size(); i++)
            if (sel < 0 && mq[i].st == 1) sel = i;
        rec = (mq.size() > 0) && (mq[0].st == 2);
        enq = enq_valid && (mq.size() < DEPTH);
        for (int i = 0; i < mq.size(); i++) begin
            e = mq[i];
            if (e.st == 0) begin
                if (wb_hit(e.t1)) e.ok1 = 1'b1;
                if (wb_hit(e.t2)) e.ok2 = 1'b1;
                if (e.ok1 && e.ok2) e.st = 1;
                mq[i] = e;
            end
        end
        if (sel >= 0 && iss_ready) begin
            e = mq[sel];
            e.st = 2;
            mq[sel] = e;
        end
        if (rec) void'(mq.pop_front());
        if (enq) begin
            e.pl  = enq_payload;
            e.t1  = enq_src1_tag;
            e.t2  = enq_src2_tag;
            e.ok1 = enq_src1_rdy || enq_src1_tag == 0 || wb_hit(enq_src1_tag);
            e.ok2 = enq_src2_rdy || enq_src2_tag == 0 || wb_hit(enq_src2_tag);
            e.st  = (e.ok1 && e.ok2) ? 1 : 0;
            mq.push_back(e);
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cyc();
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        flush = 0; enq_valid = 0; enq_payload = '0;
        enq_src1_tag = '0; enq_src2_tag = '0; enq_src1_rdy = 0; enq_src2_rdy = 0;
        wb_valid = '0; wb_tag = '0; iss_ready = 0;
    endtask

    task automatic set_enq(input logic [PW-1:0] pl, input logic [TAG_W-1:0] t1, input logic r1,
                           input logic [TAG_W-1:0] t2, input logic r2);
        enq_valid = 1; enq_payload = pl;
        enq_src1_tag = t1; enq_src1_rdy = r1; enq_src2_tag = t2; enq_src2_rdy = r2;
    endtask

    task automatic async_reset();
        rst = 1'b1;
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_enq_ready", 64'(enq_ready), 64'd1);
        check("rst_iss_valid", 64'(iss_valid), 64'd0);
        check("rst_iss_payload", iss_payload, 64'd0);
        mq.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_enq_ready", 64'(enq_ready), 64'd1);
        check("rst_iss_valid", 64'(iss_valid), 64'd0);
        check("rst_iss_payload", iss_payload, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fill to full, offer a ninth, then drain oldest-first.
        for (int i = 0; i < 8; i++) begin
            idle(); set_enq(64'(i), 6'(i + 20), 1, 6'(i + 30), 1);
            cyc();
        end
        idle();
        check("full_count", 64'(count), 64'd8);
        check("full_enq_ready", 64'(enq_ready), 64'd0);
        set_enq(64'd99, 6'd1, 1, 6'd2, 1);
        cyc();
        check("ninth_ignored", 64'(count), 64'd8);
        idle(); iss_ready = 1;
        for (int i = 0; i < 10; i++) cyc();
        check("drained", 64'(count), 64'd0);

        // Younger ready entry passes an older waiting one; wakeup next cycle.
        idle(); set_enq(64'hA, 6'd5, 0, 6'd0, 0); cyc();
        idle(); set_enq(64'hB, 6'd1, 1, 6'd2, 1); cyc();
        idle(); iss_ready = 1;
        #1;
        check("bypass_old", iss_payload, 64'hB);
        cyc();
        idle(); wb_valid = 2'b10; wb_tag = {6'd5, 6'd0}; cyc();
        idle();
        #1;
        check("wakeup_valid", 64'(iss_valid), 64'd1);
        check("wakeup_payload", iss_payload, 64'hA);
        iss_ready = 1;
        for (int i = 0; i < 4; i++) cyc();

        // Enqueue with a source satisfied by the same-cycle broadcast.
        idle(); set_enq(64'hC9, 6'd9, 0, 6'd0, 0); wb_valid = 2'b01; wb_tag = {6'd0, 6'd9};
        #1;
        check("no_zero_latency", 64'(iss_valid), 64'd0);
        cyc();
        idle();
        #1;
        check("enq_bypass", iss_payload, 64'hC9);
        iss_ready = 1;
        for (int i = 0; i < 3; i++) cyc();

        // Full queue with head issued: enqueue rejected, then accepted.
        for (int i = 0; i < 8; i++) begin
            idle(); set_enq(64'(100 + i), 6'd0, 0, 6'd0, 0); cyc();
        end
        idle(); iss_ready = 1; cyc();
        idle(); set_enq(64'd200, 6'd0, 1, 6'd0, 1); cyc();
        check("full_reclaim_count", 64'(count), 64'd7);
        set_enq(64'd201, 6'd0, 1, 6'd0, 1); cyc();
        check("refill_count", 64'(count), 64'd8);

        // Flush with concurrent enqueue.
        idle(); flush = 1; cyc();
        for (int i = 0; i < 5; i++) begin
            idle(); set_enq(64'(300 + i), 6'd3, 0, 6'd0, 1); cyc();
        end
        idle(); flush = 1; set_enq(64'd400, 6'd0, 1, 6'd0, 1); cyc();
        idle();
        check("flush_count", 64'(count), 64'd0);
        check("flush_iss_valid", 64'(iss_valid), 64'd0);

        // Pointer wrap: 20 entries through an 8-deep queue.
        for (int i = 0; i < 24; i++) begin
            idle(); iss_ready = 1;
            if (i < 20) set_enq(64'(500 + i), 6'd0, 1, 6'd0, 1);
            cyc();
        end
        for (int i = 0; i < 4; i++) begin idle(); iss_ready = 1; cyc(); end
        check("wrap_count", 64'(count), 64'd0);

        // Async reset in the middle of traffic.
        for (int i = 0; i < 4; i++) begin
            idle(); set_enq(64'(600 + i), 6'd0, 1, 6'd0, 1); cyc();
        end
        idle();
        #2;
        async_reset();

        // Random traffic.
        for (int n = 0; n < 2000; n++) begin
            idle();
            enq_valid    = ($urandom % 4) != 0;
            enq_payload  = {$urandom, $urandom};
            enq_src1_tag = 6'($urandom % 8);
            enq_src2_tag = 6'($urandom % 8);
            enq_src1_rdy = ($urandom % 3) == 0;
            enq_src2_rdy = ($urandom % 3) == 0;
            wb_valid     = 2'($urandom % 4);
            wb_tag       = {6'($urandom % 8), 6'($urandom % 8)};
            iss_ready    = ($urandom % 2) != 0;
            flush        = ($urandom % 60) == 0;
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 Parameter DEPTH, default 8, number of entries; power of two, 2..64.
REQ-002 Parameter TAG_W, default 6, physical register tag width.
REQ-003 Parameter PAYLOAD_W, default 64, opaque decoded-instruction payload width.
REQ-004 Parameter WB_PORTS, default 2, number of writeback wakeup broadcast ports.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 flush  in  1  synchronous squash of all entries.
REQ-008 enq_valid  in  1  decoder offers an instruction.
REQ-009 enq_ready  out  1  queue accepts; high iff count < DEPTH.
REQ-010 enq_payload  in  PAYLOAD_W  instruction payload.
REQ-011 enq_src1_tag, enq_src2_tag  in  TAG_W each  source tags.
REQ-012 enq_src1_rdy, enq_src2_rdy  in  1 each  source already available at register file.
REQ-013 wb_valid  in  WB_PORTS  per-port broadcast valid.
REQ-014 wb_tag  in  WB_PORTS*TAG_W  per-port broadcast tag, port p at bits [p*TAG_W +: TAG_W].
REQ-015 iss_valid  out  1  a ready entry is offered.
REQ-016 iss_ready  in  1  execute stage accepts.
REQ-017 iss_payload  out  PAYLOAD_W  payload of offered entry.
REQ-018 count  out  $clog2(DEPTH)+1  occupied slots, including issued-not-reclaimed.

Function
REQ-019 Circular buffer: head_ptr, tail_ptr $clog2(DEPTH) bits, wrap modulo DEPTH; per-entry state FREE, WAITING, READY, ISSUED.
REQ-020 Enqueue fires when enq_valid && enq_ready && !flush: slot[tail] written, tail+1, count+1.
REQ-021 New entry state READY if each source is satisfied, else WAITING; source satisfied if its rdy bit set, tag == 0, or tag matches any wb_tag with wb_valid in the same cycle (enqueue bypass).
REQ-022 Wakeup: each WAITING entry compares both pending tags against all valid wb ports each cycle; matching sources marked satisfied; entry becomes READY next edge once both satisfied.
REQ-023 Select: iss_valid combinational, high iff any entry is READY (registered state); iss_payload from oldest READY entry, age order scanning from head_ptr with wrap.
REQ-024 Entry enqueued in cycle N is issuable no earlier than cycle N+1; zero-latency enqueue-to-issue not permitted.
REQ-025 Issue fires when iss_valid && iss_ready && !flush: selected entry becomes ISSUED; at most one issue per cycle.
REQ-026 Reclaim: if slot[head] is ISSUED (registered), it becomes FREE, head+1, count-1; at most one reclaim per cycle; entries behind non-ISSUED head are not reclaimed.
REQ-027 Simultaneous enqueue and reclaim: count unchanged; both pointers advance.
REQ-028 enq_ready derived from registered count only; full queue with reclaim in the same cycle still shows enq_ready = 0.
REQ-029 iss_payload holds stable while iss_valid && !iss_ready unless an older entry becomes READY.
REQ-030 flush: all entries FREE, head = tail = 0, count = 0 next edge; overrides enqueue, issue, wakeup that cycle.
REQ-031 count never exceeds DEPTH nor underflows; enqueue while full is ignored with no state change.

Reset
REQ-032 rst asserted: immediately, without clock, all entries FREE, head_ptr = tail_ptr = 0, count = 0.
REQ-033 During reset: enq_ready = 1, iss_valid = 0, iss_payload = 0.
REQ-034 rst mid-operation discards all pending/issued entries; no partial state survives.

Verification
REQ-035 Reset, 8 enqueues all srcs rdy -> count 8, enq_ready 0; 9th enq_valid ignored; issue order payloads 0..7 oldest-first.
REQ-036 Enqueue A (src1 tag 5 not rdy), B (all rdy) -> B issues first; wb tag 5 in cycle N -> A iss_valid at N+1.
REQ-037 Enqueue with src tag 9 not rdy while wb_tag=9 valid same cycle -> entry READY, issuable next cycle.
REQ-038 Fill, drain, refill 20 entries with DEPTH=8 -> pointers wrap, payload order preserved, count returns 0.
REQ-039 Full queue, head ISSUED, enq_valid same cycle -> enq rejected, count 7 next cycle, enq accepted following cycle.
REQ-040 flush with 5 entries and concurrent enq_valid -> count 0, iss_valid 0 next cycle; async rst mid-stream -> outputs at reset values before next edge.
